mw_pipe_stage: RTL and testbench
================================

# mw_pipe_stage

Parametrised MEM→WB pipeline stage for the RV64I core. It replaces the fixed MEM/WB register with a valid/ready stage that has a one-entry skid buffer, flush support, and in-stage load extraction (byte offset plus sign/zero extension). It also selects the writeback source, so the W stage receives final register-file write data, destination and enable.

## Interface
Parameters:
- XLEN, 64, datapath width for ALU result, load data and writeback data; must be 32 or 64.
- PC_W, 64, width of the program counter.
- SKID_EN, 1, 1 instantiates the skid entry; 0 gives a plain stall register with ready_M = ready_W | ~valid_W.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous, active-low reset. One clock, no other resets.
- valid_M  in  1  M stage presents an instruction.
- ready_M  out  1  stage can accept. When SKID_EN=1, this is registered: ready_M = ~skid_valid.
- alu_out_M  in  XLEN  ALU result; bits [2:0] are the load byte offset.
- ld_data_M  in  XLEN  raw, XLEN-aligned load word from memory.
- current_pc_M  in  PC_W  instruction PC.
- rd_M  in  5  destination register.
- reg_we_M  in  1  register write enable.
- wb_sel_M  in  2  writeback source: 0 = ALU, 1 = load, 2 = PC+4, 3 = reserved (treated as ALU).
- ld_funct3_M  in  3  load type.
- flush  in  1  kill all held contents.
- valid_W  out  1  W stage holds a valid instruction.
- ready_W  in  1  W stage consumes this cycle.
- wb_data_W  out  XLEN  final writeback data.
- rd_W  out  5  destination register.
- reg_we_W  out  1  write enable, already ANDed with valid_W.
- current_pc_W  out  PC_W  PC of the instruction in W.

## Operation
- Writeback data is formed combinationally on the M side, then registered.
- Load extraction:
  - Shift ld_data_M right by alu_out_M[2:0]*8 (for XLEN=32, use offset [1:0]).
  - Apply funct3: 000 LB sign-8, 001 LH sign-16, 010 LW sign-32, 011 LD full, 100 LBU zero-8, 101 LHU zero-16, 110 LWU zero-32, 111 full.
  - For XLEN=32, 011/110/111 produce the full 32-bit word.
  - Misaligned offsets are not trapped here; the shifted result is used and the upper bytes are zero-filled by the shift.
- PC+4 is computed as current_pc_M + 4, truncated to XLEN (zero-extended if PC_W < XLEN).
- Storage:
  - Output register `out` holds {valid, wb_data, rd, we, pc}.
  - Optional skid register `sk` has the same fields.
- Transfer into the stage: valid_M & ready_M.
- Transfer out of the stage: valid_W & ready_W.
- Per-cycle update, when flush=0:
  - If `out` is empty or drains this cycle: `out` loads from `sk` if sk valid, else from an accepted input, else becomes empty. sk is cleared when it is used.
  - If `out` stays full and an input is accepted: the input goes to `sk`.
- Flush: at the next edge `out` and `sk` both become invalid, and any input accepted in that cycle is dropped. The payload fields may keep stale values, but reg_we_W must read 0 while valid_W=0.
- Ordering is strictly FIFO. The stage holds at most 2 instructions with SKID_EN=1, or 1 with SKID_EN=0.

## Timing
- Reset (rst=0, asynchronous): valid_W=0, wb_data_W=0, rd_W=0, reg_we_W=0, current_pc_W=0, sk cleared, ready_M=1.
- Latency: an accepted input appears on the W outputs at the next posedge when `out` is free, so 1 cycle. Through the skid entry it takes ≥2 cycles.
- W outputs are registered only; there is no combinational path from M inputs to W outputs.
- With SKID_EN=1, ready_M has no combinational dependence on ready_W. It drops the cycle after a skid load and rises the cycle after the skid drains.
- Flush has priority over accept and drain in the same cycle. A drain that happens in the flush cycle still counts as consumed by W.
- Reset asserted mid-operation: all valids are cleared immediately (asynchronously). The first accept can occur on the first posedge after rst=1.

## Test plan
- Reset, then one ALU op (alu_out_M=0x1234, rd=5, we=1, wb_sel=0) with ready_W=1 → next cycle valid_W=1, wb_data_W=0x1234, rd_W=5, reg_we_W=1; following cycle valid_W=0.
- Load extraction with ld_data_M=0x8877_6655_4433_2211 and wb_sel=1:
  - LB at offset 7 → 0xFFFF_FFFF_FFFF_FF88.
  - LHU at offset 6 → 0x8877.
  - LW at offset 4 → 0xFFFF_FFFF_8877_6655.
  - LD at offset 0 → full word.
- JAL-style wb_sel=2 with pc=0x8000_0FFC → wb_data_W=0x8000_1000.
- Backpressure with SKID_EN=1:
  - Drive 3 back-to-back inputs A, B, C while ready_W=0 → A held in `out`, B in `sk`, ready_M=0 the cycle after B, C stalled.
  - Raise ready_W → W sees A, B, C in order with no loss or duplication.
- Flush while `out` and `sk` are full and valid_M=1 → next cycle valid_W=0, reg_we_W=0, ready_M=1. None of the three instructions ever appears at W.
- Assert rst mid-stream with `sk` full → outputs go to zero without waiting for a clock edge. After release, a fresh input flows with 1-cycle latency.

Source files
------------

// File: rtl/mw_pipe_stage.sv
// MEM->WB pipeline stage: valid/ready handshake with optional one-entry skid,
// flush, in-stage load extraction and writeback source selection.
module mw_pipe_stage #(
    parameter int XLEN    = 64,
    parameter int PC_W    = 64,
    parameter int SKID_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_M,
    output logic            ready_M,
    input  logic [XLEN-1:0] alu_out_M,
    input  logic [XLEN-1:0] ld_data_M,
    input  logic [PC_W-1:0] current_pc_M,
    input  logic [4:0]      rd_M,
    input  logic            reg_we_M,
    input  logic [1:0]      wb_sel_M,
    input  logic [2:0]      ld_funct3_M,
    input  logic            flush,
    output logic            valid_W,
    input  logic            ready_W,
    output logic [XLEN-1:0] wb_data_W,
    output logic [4:0]      rd_W,
    output logic            reg_we_W,
    output logic [PC_W-1:0] current_pc_W
);

    localparam int OFF_W = (XLEN == 64) ? 3 : 2;
    localparam int PW    = XLEN + 5 + 1 + PC_W;

    logic [OFF_W-1:0] ld_off;
    logic [XLEN-1:0]  ld_shifted;
    logic [XLEN-1:0]  ld_value;
    logic [PC_W-1:0]  pc_sum;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  wb_data_next;
    logic [PW-1:0]    in_payload;

    assign ld_off     = alu_out_M[OFF_W-1:0];
    assign ld_shifted = ld_data_M >> {ld_off, 3'b000};

    // Size casts of signed slices do the sign extension; for XLEN=32 the
    // 32-bit cases collapse to the full word automatically.
    always_comb begin
        ld_value = ld_shifted;
        case (ld_funct3_M)
            3'b000:  ld_value = XLEN'($signed(ld_shifted[7:0]));
            3'b001:  ld_value = XLEN'($signed(ld_shifted[15:0]));
            3'b010:  ld_value = XLEN'($signed(ld_shifted[31:0]));
            3'b100:  ld_value = XLEN'(ld_shifted[7:0]);
            3'b101:  ld_value = XLEN'(ld_shifted[15:0]);
            3'b110:  ld_value = XLEN'(ld_shifted[31:0]);
            default: ld_value = ld_shifted;
        endcase
    end

    assign pc_sum   = current_pc_M + PC_W'(4);
    assign pc_plus4 = XLEN'(pc_sum);

    always_comb begin
        case (wb_sel_M)
            2'd1:    wb_data_next = ld_value;
            2'd2:    wb_data_next = pc_plus4;
            default: wb_data_next = alu_out_M;
        endcase
    end

    assign in_payload = {wb_data_next, rd_M, reg_we_M, current_pc_M};

    logic          out_valid_reg, out_valid_next;
    logic [PW-1:0] out_payload_reg, out_payload_next;
    logic          sk_valid;
    logic [PW-1:0] sk_payload;
    logic          accept;
    logic          out_free;

    assign accept   = valid_M & ready_M;
    assign out_free = ~out_valid_reg | ready_W;

    // The skid entry always has priority over new input so order is kept.
    always_comb begin
        out_valid_next   = out_valid_reg;
        out_payload_next = out_payload_reg;
        if (flush) begin
            out_valid_next = 1'b0;
        end else if (out_free) begin
            if (sk_valid) begin
                out_valid_next   = 1'b1;
                out_payload_next = sk_payload;
            end else if (accept) begin
                out_valid_next   = 1'b1;
                out_payload_next = in_payload;
            end else begin
                out_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_reg   <= 1'b0;
            out_payload_reg <= '0;
        end else begin
            out_valid_reg   <= out_valid_next;
            out_payload_reg <= out_payload_next;
        end
    end

    generate
        if (SKID_EN != 0) begin : g_skid
            logic          sk_valid_reg;
            logic [PW-1:0] sk_payload_reg;
            logic          sk_load;
            logic          sk_clear;

            assign sk_load  = ~flush & ~out_free & accept;
            assign sk_clear = flush | (out_free & sk_valid_reg);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sk_valid_reg   <= 1'b0;
                    sk_payload_reg <= '0;
                end else if (sk_clear) begin
                    sk_valid_reg <= 1'b0;
                end else if (sk_load) begin
                    sk_valid_reg   <= 1'b1;
                    sk_payload_reg <= in_payload;
                end
            end

            assign sk_valid   = sk_valid_reg;
            assign sk_payload = sk_payload_reg;
            assign ready_M    = ~sk_valid_reg;
        end else begin : g_noskid
            assign sk_valid   = 1'b0;
            assign sk_payload = '0;
            assign ready_M    = ready_W | ~out_valid_reg;
        end
    endgenerate

    logic out_we;

    assign {wb_data_W, rd_W, out_we, current_pc_W} = out_payload_reg;
    assign valid_W  = out_valid_reg;
    assign reg_we_W = out_we & out_valid_reg;

endmodule

// File: tb/tb_mw_pipe_stage.sv
// Directed bench for mw_pipe_stage (XLEN=64, SKID_EN=1): reset, ALU/load/PC+4
// writeback, skid backpressure, flush and asynchronous mid-stream reset.
module tb_mw_pipe_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_M = 1'b0;
    logic        ready_M;
    logic [63:0] alu_out_M = '0;
    logic [63:0] ld_data_M = '0;
    logic [63:0] current_pc_M = '0;
    logic [4:0]  rd_M = '0;
    logic        reg_we_M = 1'b0;
    logic [1:0]  wb_sel_M = '0;
    logic [2:0]  ld_funct3_M = '0;
    logic        flush = 1'b0;
    logic        valid_W;
    logic        ready_W = 1'b0;
    logic [63:0] wb_data_W;
    logic [4:0]  rd_W;
    logic        reg_we_W;
    logic [63:0] current_pc_W;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] LD_WORD = 64'h8877_6655_4433_2211;

    mw_pipe_stage #(.XLEN(64), .PC_W(64), .SKID_EN(1)) dut (
        .clk(clk), .rst(rst),
        .valid_M(valid_M), .ready_M(ready_M),
        .alu_out_M(alu_out_M), .ld_data_M(ld_data_M),
        .current_pc_M(current_pc_M), .rd_M(rd_M), .reg_we_M(reg_we_M),
        .wb_sel_M(wb_sel_M), .ld_funct3_M(ld_funct3_M), .flush(flush),
        .valid_W(valid_W), .ready_W(ready_W), .wb_data_W(wb_data_W),
        .rd_W(rd_W), .reg_we_W(reg_we_W), .current_pc_W(current_pc_W)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] alu, input logic [63:0] pc,
                         input logic [4:0] rd, input logic we, input logic [1:0] sel,
                         input logic [2:0] f3);
        valid_M      = v;
        alu_out_M    = alu;
        current_pc_M = pc;
        rd_M         = rd;
        reg_we_M     = we;
        wb_sel_M     = sel;
        ld_funct3_M  = f3;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        checks++; if (valid_W !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid_W); end
        checks++; if (wb_data_W !== 64'h0) begin errors++; $display("FAIL reset_wb got %h want 0", wb_data_W); end
        checks++; if (rd_W !== 5'd0 || reg_we_W !== 1'b0) begin errors++; $display("FAIL reset_rd_we got %0d/%0b want 0/0", rd_W, reg_we_W); end
        checks++; if (current_pc_W !== 64'h0) begin errors++; $display("FAIL reset_pc got %h want 0", current_pc_W); end
        checks++; if (ready_M !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", ready_M); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        $display("reset: done");
    endtask

    task automatic test_alu();
        ready_W = 1'b1;
        drive(1'b1, 64'h1234, 64'h100, 5'd5, 1'b1, 2'd0, 3'b000);
        tick();
        drive(1'b0, '0, '0, '0, 1'b0, 2'd0, 3'b000);
        checks++; if (valid_W !== 1'b1) begin errors++; $display("FAIL alu_valid got %0b want 1", valid_W); end
        checks++; if (wb_data_W !== 64'h1234) begin errors++; $display("FAIL alu_data got %h want 1234", wb_data_W); end
        checks++; if (rd_W !== 5'd5 || reg_we_W !== 1'b1) begin errors++; $display("FAIL alu_rd_we got %0d/%0b want 5/1", rd_W, reg_we_W); end
        checks++; if (current_pc_W !== 64'h100) begin errors++; $display("FAIL alu_pc got %h want 100", current_pc_W); end
        $display("alu: wb_data_W=%h rd_W=%0d", wb_data_W, rd_W);
        tick();
        checks++; if (valid_W !== 1'b0 || reg_we_W !== 1'b0) begin errors++; $display("FAIL alu_drain got %0b/%0b want 0/0", valid_W, reg_we_W); end
    endtask

    task automatic test_load();
        logic [63:0] offs [8] = '{64'd7, 64'd6, 64'd4, 64'd0, 64'd7, 64'd2, 64'd4, 64'd3};
        logic [2:0]  f3s  [8] = '{3'b000, 3'b101, 3'b010, 3'b011, 3'b100, 3'b001, 3'b110, 3'b011};
        logic [63:0] exps [8] = '{64'hFFFF_FFFF_FFFF_FF88, 64'h0000_0000_0000_8877,
                                  64'hFFFF_FFFF_8877_6655, 64'h8877_6655_4433_2211,
                                  64'h0000_0000_0000_0088, 64'h0000_0000_0000_4433,
                                  64'h0000_0000_8877_6655, 64'h0000_0088_7766_5544};
        ready_W   = 1'b1;
        ld_data_M = LD_WORD;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, offs[i], 64'h200, 5'd7, 1'b1, 2'd1, f3s[i]);
            tick();
            drive(1'b0, '0, '0, '0, 1'b0, 2'd0, 3'b000);
            checks++;
            if (valid_W !== 1'b1 || wb_data_W !== exps[i]) begin
                errors++;
                $display("FAIL load_%0d f3=%b off=%0d got %h (v=%0b) want %h", i, f3s[i], offs[i], wb_data_W, valid_W, exps[i]);
            end
            $display("load: f3=%b off=%0d wb_data_W=%h", f3s[i], offs[i], wb_data_W);
            tick();
        end
    endtask

    task automatic test_jal();
        ready_W = 1'b1;
        drive(1'b1, 64'hDEAD, 64'h8000_0FFC, 5'd1, 1'b1, 2'd2, 3'b000);
        tick();
        drive(1'b0, '0, '0, '0, 1'b0, 2'd0, 3'b000);
        checks++; if (wb_data_W !== 64'h8000_1000) begin errors++; $display("FAIL jal_data got %h want 80001000", wb_data_W); end
        checks++; if (current_pc_W !== 64'h8000_0FFC) begin errors++; $display("FAIL jal_pc got %h want 80000ffc", current_pc_W); end
        $display("jal: wb_data_W=%h", wb_data_W);
        drive(1'b1, 64'h5555, 64'h0, 5'd2, 1'b1, 2'd3, 3'b000);
        tick();
        drive(1'b0, '0, '0, '0, 1'b0, 2'd0, 3'b000);
        checks++; if (wb_data_W !== 64'h5555) begin errors++; $display("FAIL sel3_data got %h want 5555", wb_data_W); end
        tick();
    endtask

    task automatic test_back_to_back();
        ready_W = 1'b0;
        drive(1'b1, 64'hA, 64'h10, 5'd1, 1'b1, 2'd0, 3'b000);
        tick();
        checks++; if (valid_W !== 1'b1 || wb_data_W !== 64'hA || ready_M !== 1'b1) begin errors++; $display("FAIL bp_a got v=%0b d=%h r=%0b want 1/a/1", valid_W, wb_data_W, ready_M); end
        drive(1'b1, 64'hB, 64'h14, 5'd2, 1'b1, 2'd0, 3'b000);
        tick();
        checks++; if (ready_M !== 1'b0 || wb_data_W !== 64'hA) begin errors++; $display("FAIL bp_skid got r=%0b d=%h want 0/a", ready_M, wb_data_W); end
        drive(1'b1, 64'hC, 64'h18, 5'd3, 1'b1, 2'd0, 3'b000);
        tick();
        checks++; if (ready_M !== 1'b0 || wb_data_W !== 64'hA || valid_W !== 1'b1) begin errors++; $display("FAIL bp_stall got r=%0b d=%h want 0/a", ready_M, wb_data_W); end
        ready_W = 1'b1;
        tick();
        checks++; if (wb_data_W !== 64'hB || rd_W !== 5'd2 || ready_M !== 1'b1) begin errors++; $display("FAIL bp_b got d=%h rd=%0d r=%0b want b/2/1", wb_data_W, rd_W, ready_M); end
        $display("back_to_back: W sees %h", wb_data_W);
        tick();
        drive(1'b0, '0, '0, '0, 1'b0, 2'd0, 3'b000);
        checks++; if (wb_data_W !== 64'hC || rd_W !== 5'd3 || valid_W !== 1'b1) begin errors++; $display("FAIL bp_c got d=%h rd=%0d v=%0b want c/3/1", wb_data_W, rd_W, valid_W); end
        $display("back_to_back: W sees %h", wb_data_W);
        tick();
        checks++; if (valid_W !== 1'b0) begin errors++; $display("FAIL bp_nodup got v=%0b d=%h want 0", valid_W, wb_data_W); end
    endtask

    task automatic test_flush();
        ready_W = 1'b0;
        drive(1'b1, 64'h21, 64'h20, 5'd4, 1'b1, 2'd0, 3'b000);
        tick();
        drive(1'b1, 64'h22, 64'h24, 5'd5, 1'b1, 2'd0, 3'b000);
        tick();
        drive(1'b1, 64'h23, 64'h28, 5'd6, 1'b1, 2'd0, 3'b000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 2'd0, 3'b000);
        checks++; if (valid_W !== 1'b0 || reg_we_W !== 1'b0) begin errors++; $display("FAIL flush_out got v=%0b we=%0b want 0/0", valid_W, reg_we_W); end
        checks++; if (ready_M !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b want 1", ready_M); end
        ready_W = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (valid_W !== 1'b0) begin errors++; $display("FAIL flush_leak_%0d got v=%0b d=%h want 0", i, valid_W, wb_data_W); end
        end
        $display("flush: stage empty");
    endtask

    task automatic test_reset_mid();
        ready_W = 1'b0;
        drive(1'b1, 64'h31, 64'h30, 5'd8, 1'b1, 2'd0, 3'b000);
        tick();
        drive(1'b1, 64'h32, 64'h34, 5'd9, 1'b1, 2'd0, 3'b000);
        tick();
        drive(1'b1, 64'h40, 64'h44, 5'd10, 1'b1, 2'd0, 3'b000);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (valid_W !== 1'b0 || reg_we_W !== 1'b0 || wb_data_W !== 64'h0) begin errors++; $display("FAIL rstmid_out got v=%0b we=%0b d=%h want 0/0/0", valid_W, reg_we_W, wb_data_W); end
        checks++; if (rd_W !== 5'd0 || current_pc_W !== 64'h0 || ready_M !== 1'b1) begin errors++; $display("FAIL rstmid_misc got rd=%0d pc=%h r=%0b want 0/0/1", rd_W, current_pc_W, ready_M); end
        ready_W = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        tick();
        drive(1'b0, '0, '0, '0, 1'b0, 2'd0, 3'b000);
        checks++; if (valid_W !== 1'b1 || wb_data_W !== 64'h40 || rd_W !== 5'd10) begin errors++; $display("FAIL rstmid_fresh got v=%0b d=%h rd=%0d want 1/40/10", valid_W, wb_data_W, rd_W); end
        $display("reset_mid: fresh wb_data_W=%h", wb_data_W);
        tick();
        checks++; if (valid_W !== 1'b0) begin errors++; $display("FAIL rstmid_drain got v=%0b want 0", valid_W); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_jal();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
